// File: rtl/mem_bus_interface.sv
// Memory-access sequencer: turns controller rd/wr strobes into a 4-phase req/ack handshake.
// Optional abort-on-timeout logic is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_interface #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wait_,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              w_strobe;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
`endif

    assign w_strobe = rd | wr;

    // Combinational so the controller can branch on wait_ in the very cycle it strobes.
    assign wait_ = (r_state != ST_IDLE) | w_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_cnt         <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here; the default below is overridden later in the same block.
            r_rdata_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_strobe) begin
                        r_mem_addr  <= addr;
                        r_mem_wdata <= wdata;
                        r_mem_we    <= wr;
                        r_mem_req   <= 1'b1;
                        r_state     <= ST_REQ;
`ifdef BUS_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdata       <= mem_rdata;
                            r_rdata_valid <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RELEASE;
`ifdef BUS_TIMEOUT_EN
                        r_cnt     <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        if (!r_mem_we) begin
                            r_rdata       <= '1;
                            r_rdata_valid <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!mem_ack) begin
                        r_state <= ST_IDLE;
`ifdef BUS_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;

`ifdef BUS_TIMEOUT_EN
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface: each step drives one cycle of inputs, then checks outputs.
// Timeout scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_interface;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              wait_;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              bus_err;

    int n_cmp = 0;
    int n_err = 0;
    int wait_cnt;

    mem_bus_interface #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .wait_       (wait_),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Land 1 time unit after the rising edge: the new cycle has begun.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #12;
        check("rst_req",   mem_req, 0);
        check("rst_wait",  wait_, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_err",   bus_err, 0);
        rst_n = 1'b1;
        next_cycle();

        // Read 0x123: ack in first REQ cycle, drop in RELEASE
        rd = 1'b1; addr = 12'h123; #1;
        check("rd_c0_wait", wait_, 1);
        check("rd_c0_req",  mem_req, 0);
        next_cycle();
        rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF; #1;
        check("rd_c1_req",  mem_req, 1);
        check("rd_c1_addr", mem_addr, 12'h123);
        check("rd_c1_we",   mem_we, 0);
        check("rd_c1_wait", wait_, 1);
        check("rd_c1_vld",  rdata_valid, 0);
        next_cycle();
        mem_ack = 1'b0; #1;
        check("rd_c2_req",   mem_req, 0);
        check("rd_c2_rdata", rdata, 16'hBEEF);
        check("rd_c2_vld",   rdata_valid, 1);
        check("rd_c2_wait",  wait_, 1);
        next_cycle();
        #1;
        check("rd_c3_wait",  wait_, 0);
        check("rd_c3_vld",   rdata_valid, 0);
        check("rd_c3_rdata", rdata, 16'hBEEF);

        // Write 0x5A5A to 0x0FF, ack on 4th REQ cycle
        next_cycle();
        wr = 1'b1; addr = 12'h0FF; wdata = 16'h5A5A; mem_rdata = 16'h1111; #1;
        wait_cnt = wait_ ? 1 : 0;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            wr = 1'b0; mem_ack = (k == 4); #1;
            if (wait_) wait_cnt++;
            check("wr_vld",   rdata_valid, 0);
            check("wr_rdata", rdata, 16'hBEEF);
            if (k <= 5) begin
                check("wr_req",   mem_req, (k <= 4) ? 1 : 0);
                check("wr_we",    mem_we, 1);
                check("wr_addr",  mem_addr, 12'h0FF);
                check("wr_wdata", mem_wdata, 16'h5A5A);
            end
        end
        check("wr_wait_cycles", wait_cnt, 6);
        check("wr_c6_wait", wait_, 0);
        mem_ack = 1'b0;

        // rd and wr together: write wins; rd during RELEASE ignored
        next_cycle();
        rd = 1'b1; wr = 1'b1; addr = 12'h055; wdata = 16'h1234; mem_rdata = 16'h0BAD; #1;
        next_cycle();
        rd = 1'b0; wr = 1'b0; mem_ack = 1'b1; #1;
        check("sim_we",   mem_we, 1);
        check("sim_req",  mem_req, 1);
        check("sim_addr", mem_addr, 12'h055);
        next_cycle();
        rd = 1'b1; #1;
        check("sim_rel_req",  mem_req, 0);
        check("sim_rel_vld",  rdata_valid, 0);
        check("sim_rel_wait", wait_, 1);
        next_cycle();
        rd = 1'b0; mem_ack = 1'b0; #1;
        check("sim_rel2_req",  mem_req, 0);
        check("sim_rel2_wait", wait_, 1);
        next_cycle();
        #1;
        check("sim_idle_req",   mem_req, 0);
        check("sim_idle_wait",  wait_, 0);
        check("sim_idle_rdata", rdata, 16'hBEEF);
        next_cycle();
        #1;
        check("sim_no_2nd_req", mem_req, 0);

        // Ack already high before req rises
        mem_ack = 1'b1; rd = 1'b1; addr = 12'h200; mem_rdata = 16'hCAFE; #1;
        check("ah_c0_req", mem_req, 0);
        next_cycle();
        rd = 1'b0; #1;
        check("ah_c1_req", mem_req, 1);
        next_cycle();
        #1;
        check("ah_c2_req",   mem_req, 0);
        check("ah_c2_vld",   rdata_valid, 1);
        check("ah_c2_rdata", rdata, 16'hCAFE);
        check("ah_c2_addr",  mem_addr, 12'h200);
        next_cycle();
        #1;
        check("ah_c3_wait", wait_, 1);
        check("ah_c3_vld",  rdata_valid, 0);
        check("ah_c3_req",  mem_req, 0);
        mem_ack = 1'b0;
        next_cycle();
        #1;
        check("ah_c4_wait", wait_, 0);

`ifdef BUS_TIMEOUT_EN
        // Read with ack stuck low: abort after TIMEOUT REQ cycles
        rd = 1'b1; addr = 12'h321; #1;
        wait_cnt = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            next_cycle();
            rd = 1'b0; #1;
            if (mem_req) wait_cnt++;
        end
        check("to_req_cycles", wait_cnt, TIMEOUT);
        next_cycle();
        #1;
        check("to_req",   mem_req, 0);
        check("to_err",   bus_err, 1);
        check("to_rdata", rdata, 16'hFFFF);
        check("to_vld",   rdata_valid, 1);
        check("to_wait",  wait_, 0);
        rd = 1'b1; addr = 12'h010; mem_rdata = 16'h4321; #1;
        next_cycle();
        rd = 1'b0; mem_ack = 1'b1; #1;
        next_cycle();
        mem_ack = 1'b0; #1;
        check("to_good_rdata", rdata, 16'h4321);
        check("to_err_sticky", bus_err, 1);
        next_cycle();
`else
        check("no_to_err", bus_err, 0);
`endif

        // Reset in the middle of REQ drops req immediately
        rd = 1'b1; addr = 12'h3AB; wdata = 16'h7777; #1;
        next_cycle();
        rd = 1'b0; #1;
        check("mr_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_req",   mem_req, 0);
        check("mr_wait",  wait_, 0);
        check("mr_addr",  mem_addr, 0);
        check("mr_we",    mem_we, 0);
        check("mr_wdata", mem_wdata, 0);
        check("mr_rdata", rdata, 0);
        check("mr_vld",   rdata_valid, 0);
        check("mr_err",   bus_err, 0);
        #2 rst_n = 1'b1;
        next_cycle();
        #1;
        check("mr_after_req",  mem_req, 0);
        check("mr_after_wait", wait_, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
